// File: rtl/cdc_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer entering a new clock domain.
// Because only one bit of a Gray pointer changes per increment, each stage may
// capture either the old or the new value, never a mix of unrelated bits.
//
// Ports:
//   clk_in      destination-domain clock
//   reset_in    asynchronous, active-high clear of every stage
//   gray_async  Gray pointer registered in the source domain
//   gray_sync   pointer after SYNC_STAGES destination-domain flops
module cdc_gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] gray_async,
  output logic [WIDTH-1:0] gray_sync
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_async_fifo.sv
// Dual-clock first-word-fall-through FIFO. Words written on clk_in are read on
// clk_out; the head word is presented on rd_data whenever empty is low.
// Binary pointers address the array, Gray copies of them cross the domains.
//
// Ports:
//   clk_in    write-domain clock
//   reset_in  asynchronous active-high reset for both domains
//   clk_out   read-domain clock
//   wr_en     write request (ignored while full or in reset)
//   wr_data   word to write
//   full      registered, clk_in domain
//   rd_en     pop request (ignored while empty or in reset)
//   rd_data   head word, valid while empty is low
//   empty     registered, clk_out domain
module cdc_async_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  clk_out,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  // Reset assertion is immediate in both domains; release is retimed to each
  // local clock so no flop leaves reset close to its own clock edge.
  logic [1:0] wr_rst_q;
  logic [1:0] rd_rst_q;
  logic       wr_rst;
  logic       rd_rst;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) wr_rst_q <= 2'b11;
    else          wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  always_ff @(posedge clk_out or posedge reset_in) begin
    if (reset_in) rd_rst_q <= 2'b11;
    else          rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wbin, wgray, wbin_next, wgray_next;
  logic [AW:0] rbin, rgray, rbin_next, rgray_next;
  logic [AW:0] rgray_wsync, wgray_rsync;
  logic        wr_inc, rd_inc;
  logic        full_next, empty_next;

  // Write domain
  assign wr_inc     = wr_en && !full;
  assign wbin_next  = wbin + {{AW{1'b0}}, wr_inc};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  // Full when the writer is exactly one lap ahead: in Gray code that is the
  // reader's pointer with its top two bits flipped.
  assign full_next  = (wgray_next == {~rgray_wsync[AW:AW-1], rgray_wsync[AW-2:0]});

  always_ff @(posedge clk_in or posedge wr_rst) begin
    if (wr_rst) begin
      wbin  <= '0;
      wgray <= '0;
      full  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      full  <= full_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_inc) mem[wbin[AW-1:0]] <= wr_data;
  end

  // Read domain
  assign rd_inc     = rd_en && !empty;
  assign rbin_next  = rbin + {{AW{1'b0}}, rd_inc};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign empty_next = (rgray_next == wgray_rsync);

  always_ff @(posedge clk_out or posedge rd_rst) begin
    if (rd_rst) begin
      rbin  <= '0;
      rgray <= '0;
      empty <= 1'b1;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
      empty <= empty_next;
    end
  end

  // The slot under the read pointer cannot be written while it is readable,
  // so an unregistered read of it is stable in the clk_out domain.
  assign rd_data = mem[rbin[AW-1:0]];

  // Pointer crossings
  cdc_gray_sync #(
    .WIDTH       (AW + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_to_wr (
    .clk_in     (clk_in),
    .reset_in   (wr_rst),
    .gray_async (rgray),
    .gray_sync  (rgray_wsync)
  );

  cdc_gray_sync #(
    .WIDTH       (AW + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_to_rd (
    .clk_in     (clk_out),
    .reset_in   (rd_rst),
    .gray_async (wgray),
    .gray_sync  (wgray_rsync)
  );

endmodule

// File: tb/tb_cdc_async_fifo.sv
`timescale 1ns/10ps
module tb_cdc_async_fifo;

  logic       clk_in   = 1'b0;
  logic       clk_out  = 1'b0;
  logic       reset_in = 1'b1;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       rd_en    = 1'b0;
  logic       full;
  logic       empty;
  logic [7:0] rd_data;

  real wr_half = 5.0;
  real rd_half = 20.8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       flag;
  } vec_t;

  vec_t fill_tab  [9];
  vec_t drain_tab [8];

  cdc_async_fifo #(
    .DATA_WIDTH  (8),
    .DEPTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clk_out  (clk_out),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty)
  );

  // The read clock is offset so no clk_out edge ever lands within 0.1 ns
  // of a clk_in edge at the initial ratio.
  initial forever #(wr_half) clk_in = ~clk_in;
  initial begin
    #0.3;
    forever #(rd_half) clk_out = ~clk_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    @(negedge clk_in);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk_in);
    #0.05;
    wr_en = 1'b0;
  endtask

  task automatic pop_word();
    @(negedge clk_out);
    rd_en = 1'b1;
    @(posedge clk_out);
    #0.05;
    rd_en = 1'b0;
  endtask

  task automatic wait_not_empty(input string name, input int limit);
    int n = 0;
    while (empty && n < limit) begin
      @(negedge clk_out);
      n++;
    end
    if (empty) check({name, "_timeout"}, 32'(empty), 32'd0);
  endtask

  task automatic idle_both(input int n);
    repeat (n) @(negedge clk_out);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic stream(input string name, input int nwords);
    logic [7:0] q[$];
    int writes = 0;
    int reads  = 0;
    fork
      begin : writer
        int cyc = 0;
        while (writes < nwords && cyc < 20000) begin
          @(negedge clk_in);
          cyc++;
          if ($urandom_range(0, 3) != 0 && !full) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            q.push_back(wr_data);
            writes++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge clk_in);
        wr_en = 1'b0;
        if (writes < nwords) check({name, "_wr_timeout"}, 32'(writes), 32'(nwords));
      end
      begin : reader
        int cyc = 0;
        while (reads < nwords && cyc < 20000) begin
          @(negedge clk_out);
          cyc++;
          if ($urandom_range(0, 2) != 0 && !empty) begin
            if (q.size() == 0) begin
              check({name, "_extra_word"}, 32'(rd_data), 32'hFFFF_FFFF);
              rd_en = 1'b0;
            end else begin
              check({name, "_data"}, 32'(rd_data), 32'(q.pop_front()));
              rd_en = 1'b1;
              reads++;
            end
          end else begin
            rd_en = 1'b0;
          end
        end
        @(negedge clk_out);
        rd_en = 1'b0;
        if (reads < nwords) check({name, "_rd_timeout"}, 32'(reads), 32'(nwords));
      end
    join
    idle_both(6);
    check({name, "_leftover"}, 32'(q.size()), 32'd0);
    check({name, "_empty_end"}, 32'(empty), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      fill_tab[i].data  = 8'h11 + 8'(i);
      fill_tab[i].flag  = (i == 7);
      drain_tab[i].data = 8'h11 + 8'(i);
      drain_tab[i].flag = (i == 7);
    end
    fill_tab[8].data = 8'h99;
    fill_tab[8].flag = 1'b1;

    // Reset with both clocks running; rd_en during and after reset is ignored
    repeat (3) @(negedge clk_out);
    check("reset_full", 32'(full), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    rd_en = 1'b1;
    repeat (2) @(negedge clk_out);
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (4) @(negedge clk_out);
    rd_en = 1'b0;
    check("reset_rd_ignored", 32'(empty), 32'd1);
    idle_both(4);

    // Fill to capacity, attempt overflow, then drain in order
    for (int i = 0; i < 9; i++) begin
      write_word(fill_tab[i].data);
      check($sformatf("fill_full_%0d", i), 32'(full), 32'(fill_tab[i].flag));
    end
    wait_not_empty("fill", 10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_out);
      check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(drain_tab[i].data));
      pop_word();
      check($sformatf("drain_empty_%0d", i), 32'(empty), 32'(drain_tab[i].flag));
    end
    idle_both(6);
    check("overflow_dropped", 32'(empty), 32'd1);
    check("drained_not_full", 32'(full), 32'd0);

    // First-word-fall-through latency
    write_word(8'hA5);
    n = 0;
    while (n < 3) begin
      @(posedge clk_out);
      #0.05;
      n++;
      if (!empty) break;
    end
    check("fwft_empty_fall", 32'(empty), 32'd0);
    check("fwft_data", 32'(rd_data), 32'hA5);
    pop_word();
    check("fwft_empty_after_pop", 32'(empty), 32'd1);
    idle_both(4);

    // Full release after a single pop, then one more write lands at the tail
    for (int i = 0; i < 8; i++) write_word(8'h21 + 8'(i));
    check("rel_full_set", 32'(full), 32'd1);
    wait_not_empty("rel", 10);
    @(negedge clk_out);
    check("rel_head", 32'(rd_data), 32'h21);
    pop_word();
    n = 0;
    while (n < 3) begin
      @(posedge clk_in);
      #0.05;
      n++;
      if (!full) break;
    end
    check("rel_full_fall", 32'(full), 32'd0);
    write_word(8'h77);
    check("rel_full_again", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      wait_not_empty("rel_drain", 10);
      @(negedge clk_out);
      check($sformatf("rel_drain_%0d", i), 32'(rd_data),
            (i == 7) ? 32'h77 : 32'(8'h22 + 8'(i)));
      pop_word();
    end
    check("rel_empty_end", 32'(empty), 32'd1);
    idle_both(4);

    // Reset mid-operation discards contents
    for (int i = 0; i < 3; i++) write_word(8'hC0 + 8'(i));
    idle_both(4);
    check("mid_not_empty", 32'(empty), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (2) @(negedge clk_out);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    idle_both(4);
    write_word(8'h5A);
    wait_not_empty("mid", 10);
    @(negedge clk_out);
    check("mid_data", 32'(rd_data), 32'h5A);
    pop_word();
    check("mid_empty_after", 32'(empty), 32'd1);
    idle_both(6);
    check("mid_alone", 32'(empty), 32'd1);

    // Random streaming at both clock ratios; 200 words wrap pointers many times
    stream("stream_fast_wr", 200);
    wr_half = 20.8;
    rd_half = 5.0;
    idle_both(4);
    stream("stream_slow_wr", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/cdc_async_fifo.md
Name: cdc_async_fifo

Overview:
Dual-clock FIFO that carries fixed-width words from a write clock domain (clk_in) to an independent read clock domain (clk_out). Gray-coded pointers cross between the domains through synchronizers. The read side is first-word-fall-through: the head word is already on rd_data whenever empty is low. It is the storage element of both channels of the TL-UL CDC bridge: Channel A runs 100 MHz to 24 MHz, Channel D runs 24 MHz to 100 MHz.

Parameters:
DATA_WIDTH, 32, width of each stored word in bits
DEPTH, 8, number of entries; must be a power of two and at least 4
SYNC_STAGES, 2, flip-flop stages in each pointer synchronizer; must be at least 2

Ports:
clk_in  input  1  write-domain clock
reset_in  input  1  reset, asynchronous, active-high; clock clk_in; also resets the read domain
clk_out  input  1  read-domain clock, asynchronous to clk_in
wr_en  input  1  write request, sampled on the clk_in rising edge
wr_data  input  DATA_WIDTH  word to write
full  output  1  no free entry (clk_in domain, registered)
rd_en  input  1  pop the head word, sampled on the clk_out rising edge
rd_data  output  DATA_WIDTH  head word (FWFT); valid only while empty=0
empty  output  1  no readable entry (clk_out domain, registered)

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. Writes are synchronous to clk_in. The read path is combinational: rd_data = mem[rd_addr]. The array is not reset.
- Pointers: binary plus Gray, AW+1 bits, where AW = log2(DEPTH). The extra MSB distinguishes full from empty across wrap-around.
- Write: on clk_in, if wr_en && !full, store at mem[wr_addr] and advance the write pointer. wr_en while full is ignored: no store, no pointer move.
- Read: on clk_out, if rd_en && !empty, advance the read pointer; rd_data then shows the next entry. rd_en while empty is ignored.
- Simultaneous wr_en and rd_en in their own domains are always legal. A simultaneous write and read on the same entry index cannot occur, because full/empty guard it.
- Crossing: the write Gray pointer goes through SYNC_STAGES flops on clk_out. The read Gray pointer goes through SYNC_STAGES flops on clk_in. Only Gray-coded registered values cross.
- full: registered and computed from the next write Gray pointer. It equals the synced read Gray pointer with its two MSBs inverted and the remaining bits equal. full rises on the same clk_in edge that writes the DEPTH-th outstanding word.
- empty: registered and computed as next read Gray pointer == synced write Gray pointer. empty rises on the clk_out edge that pops the last word.
- Deassertion of either flag is pessimistic. After a write, empty falls within SYNC_STAGES+1 clk_out edges. After a read, full falls within SYNC_STAGES+1 clk_in edges.
- Reset: while reset_in is high, all pointers and synchronizers in both domains are cleared asynchronously, full=0 and empty=1.
- Reset release: deassertion is synchronized separately into each domain by a 2-flop reset synchronizer. Until release, wr_en and rd_en are ignored.
- Reset mid-operation discards all contents; the FIFO restarts empty.
- Capacity is exactly DEPTH words. Pointers wrap modulo 2*DEPTH with no loss or duplication.

Decomposition:
- No shared package needed. AW = $clog2(DEPTH) is a local parameter.
- One sub-module, cdc_gray_sync: a SYNC_STAGES-deep, parameterised-width synchronizer with async clear, instantiated once per direction.
- The reset synchronizers and the binary-to-Gray conversion are inline logic.

Test Plan:
- Reset: assert reset_in with both clocks running (clk_in 100 MHz, clk_out 24 MHz, DATA_WIDTH=8, DEPTH=8) -> full=0, empty=1; rd_en pulses leave empty=1.
- Fill/overflow: write 0x11..0x18 with no reads -> full=1 right after the 8th write edge. A 9th write of 0x99 is dropped. Draining gives 0x11..0x18 in order, and empty=1 right after the 8th pop.
- FWFT latency: a single write of 0xA5 -> empty falls within 3 clk_out edges. rd_data=0xA5 before any rd_en. One rd_en -> empty=1.
- Full release: with the FIFO full, pop one word -> full falls within 3 clk_in edges. The next write, 0x77, is accepted and read out last.
- Wrap and stream: 200 random words with random wr_en/rd_en duty, repeated at the inverted clock ratio (24 MHz write, 100 MHz read) -> the scoreboard shows exact order with no loss or duplication, and both pointers wrap several times.
- Reset mid-operation: write 3 words, pulse reset_in -> empty=1, full=0. Then write 0x5A -> 0x5A is read back alone.
